ram_uart_dump: RTL and testbench

Sequencer that streams a contiguous block of bytes from a synchronous-read RAM out through the UART byte transmitter.
- Accepts a start command carrying a base address and a length.
- Reads one byte at a time and hands it to the transmitter with a single-cycle send_en pulse.
- Waits for tx_done before fetching the next byte.
- Sits between the RAM port and the UART TX, and reports busy, done, progress, abort and timeout status.

---
 rtl/ram_uart_dump.sv | 153 +++++++++++++++
 tb/tb_ram_uart_dump.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_uart_dump.sv
// Streams len bytes from a sync-read RAM to a UART TX: start->rd_en +1, send_en +3; tx_done->next send_en +4.
// Backpressure: exactly one byte in flight; the next fetch waits for tx_done or a timeout.
module ram_uart_dump #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 60000,
  parameter int TO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              send_en,
  output logic [7:0]        data_byte,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic [ADDR_W-1:0] sent_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT_DATA,
    SEND,
    WAIT_DONE,
    NEXT,
    FIN
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic              abort_q;
  logic [TO_W-1:0]   to_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              send_q;
  logic [7:0]        data_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              err_q;
  logic [ADDR_W-1:0] sent_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      abort_q   <= 1'b0;
      to_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      send_q    <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      sent_q    <= '0;
    end else begin
      rd_en_q <= 1'b0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      if (state_q != IDLE && abort) abort_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            rem_q     <= len;
            sent_q    <= '0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b1;
            if (len != '0) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_addr;
              state_q   <= RD;
            end else begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        RD: state_q <= WAIT_DATA;
        WAIT_DATA: begin
          data_q  <= rd_data;
          send_q  <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          to_q    <= '0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // tx_done takes priority over a timeout landing in the same cycle
          if (tx_done) begin
            sent_q  <= sent_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            addr_q  <= addr_q + 1'b1;
            state_q <= NEXT;
          end else if (to_q == TO_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            if (abort_q) aborted_q <= 1'b1;
            state_q <= FIN;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        NEXT: begin
          if (rem_q == '0 || abort_q) begin
            done_q  <= 1'b1;
            if (abort_q && rem_q != '0) aborted_q <= 1'b1;
            state_q <= FIN;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_q;
            state_q   <= RD;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign send_en   = send_q;
  assign data_byte = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err       = err_q;
  assign sent_cnt  = sent_q;

endmodule

// File: tb/tb_ram_uart_dump.sv
// Scoreboard bench for ram_uart_dump: RAM and UART TX models, expected addresses/bytes queued at start.
module tb_ram_uart_dump;
  localparam int TX_DLY = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] len;
  logic       abort;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       send_en;
  logic [7:0] data_byte;
  logic       tx_done;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       err;
  logic [7:0] sent_cnt;

  ram_uart_dump #(.ADDR_W(8), .TIMEOUT(100), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .send_en(send_en), .data_byte(data_byte), .tx_done(tx_done), .busy(busy),
    .done(done), .aborted(aborted), .err(err), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_start = 0;
  int last_send = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int send_cnt = 0;
  int busy_cyc = 0;
  bit tx_on = 1'b1;
  logic [7:0] mem [256];
  logic [7:0] exp_addr [$];
  logic [7:0] exp_byte [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (send_en && tx_on && !rst) begin
        repeat (TX_DLY) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        if (rd_cnt == 0) chk("rd_lat", cyc - t_start, 1);
        if (exp_addr.size() != 0) chk("rd_addr", rd_addr, exp_addr.pop_front());
        rd_cnt++;
      end
      if (send_en) begin
        if (send_cnt == 0) chk("send_lat", cyc - t_start, 3);
        else if (tx_on) chk("send_gap", cyc - last_send, TX_DLY + 4);
        if (exp_byte.size() != 0) chk("data_byte", data_byte, exp_byte.pop_front());
        last_send = cyc;
        send_cnt++;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_xfer(input logic [7:0] b, input logic [7:0] l, input int nexp);
    logic [7:0] a;
    @(posedge clk);
    #1;
    for (int i = 0; i < nexp; i++) begin
      a = b + 8'(i);
      exp_addr.push_back(a);
      exp_byte.push_back(mem[a]);
    end
    rd_cnt = 0;
    send_cnt = 0;
    busy_cyc = 0;
    t_start = cyc;
    start = 1'b1;
    base_addr = b;
    len = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int target = done_cnt + 1;
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", done_cnt, target);
  endtask

  task automatic wait_sends(input int nsend, input int budget);
    int n = 0;
    while (send_cnt < nsend && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_seen", send_cnt, nsend);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; len = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_send_en", send_en, 0);
    chk("rst_data", data_byte, 0);
    chk("rst_flags", {done, aborted, err}, 0);
    chk("rst_sent", sent_cnt, 0);

    // basic three-byte transfer
    start_xfer(8'h10, 8'd3, 3);
    wait_done(500);
    chk("t1_busy_at_done", busy, 1);
    chk("t1_sent", sent_cnt, 3);
    chk("t1_err", err, 0);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    repeat (10) @(negedge clk);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_n_send", send_cnt, 3);
    chk("t1_n_rd", rd_cnt, 3);

    // address wrap
    start_xfer(8'hFE, 8'd4, 4);
    wait_done(500);
    chk("t2_sent", sent_cnt, 4);
    chk("t2_n_rd", rd_cnt, 4);
    chk("t2_q_empty", exp_byte.size(), 0);

    // zero length
    repeat (3) @(posedge clk);
    start_xfer(8'h33, 8'd0, 0);
    wait_done(20);
    chk("t3_done_lat", done_cyc - t_start, 1);
    repeat (5) @(negedge clk);
    chk("t3_n_rd", rd_cnt, 0);
    chk("t3_n_send", send_cnt, 0);
    chk("t3_busy_cyc", busy_cyc, 1);

    // abort during the second byte
    start_xfer(8'h40, 8'd5, 2);
    wait_sends(2, 200);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done(200);
    chk("t4_aborted", aborted, 1);
    chk("t4_sent", sent_cnt, 2);
    repeat (10) @(negedge clk);
    chk("t4_n_rd", rd_cnt, 2);
    chk("t4_n_send", send_cnt, 2);

    // timeout, then the next start clears err
    tx_on = 1'b0;
    start_xfer(8'h20, 8'd2, 1);
    chk("t5_aborted_clr", aborted, 0);
    wait_done(400);
    chk("t5_to_lat", done_cyc - last_send, 101);
    chk("t5_err", err, 1);
    chk("t5_sent", sent_cnt, 0);
    repeat (5) @(posedge clk);
    tx_on = 1'b1;
    start_xfer(8'h30, 8'd1, 1);
    chk("t5_err_clr", err, 0);
    wait_done(200);
    chk("t5b_sent", sent_cnt, 1);
    chk("t5b_err", err, 0);

    // start while busy is ignored
    repeat (3) @(posedge clk);
    start_xfer(8'h50, 8'd2, 2);
    wait_sends(1, 50);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; base_addr = 8'h90; len = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(300);
    chk("t6_sent", sent_cnt, 2);
    repeat (10) @(negedge clk);
    chk("t6_n_rd", rd_cnt, 2);
    chk("t6_n_send", send_cnt, 2);

    // reset in WAIT_DONE
    start_xfer(8'h60, 8'd3, 1);
    wait_sends(1, 50);
    repeat (5) @(posedge clk);
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_rd_en", rd_en, 0);
    chk("t7_send_en", send_en, 0);
    chk("t7_data", data_byte, 0);
    chk("t7_sent", sent_cnt, 0);
    chk("t7_flags", {done, aborted, err}, 0);
    exp_addr.delete();
    exp_byte.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("t7_no_done", done_cnt, d0);
    chk("t7_idle", busy, 0);
    chk("t7_sent_idle", sent_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
